// File: rtl/slew_capture.sv
// Receive end of the time-multiplexed slew/setpoint stream: demuxes 2^aw-word frames
// into a ping-pong RAM with a stable host readback bank. SLEW_CAPTURE_CNT_EN adds frame_cnt_o.
module slew_capture #(
  parameter int dw = 18,
  parameter int aw = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stb_i,
  input  logic                 first_i,
  input  logic signed [dw-1:0] din_i,
  input  logic                 freeze_i,
  input  logic                 err_clr_i,
  input  logic        [aw-1:0] h_addr_i,
  output logic signed [dw-1:0] h_data_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic        [15:0]   frame_cnt_o
);
  localparam int N = 1 << aw;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state_q;
  logic [aw-1:0]        idx_q;
  logic                 bank_q;
  logic                 done_q;
  logic                 err_q;
  logic signed [dw-1:0] h_data_q;
  logic signed [dw-1:0] mem_q [2**(aw+1)];

  logic          we_d;
  logic [aw-1:0] waddr_d;
  logic          last_d;
  logic          publish_d;
  logic          err_set_d;

  // A first word always lands at index 0, whether it opens or restarts a frame.
  always_comb begin
    we_d      = stb_i & (first_i | (state_q == FILL)) & ~rst_i;
    waddr_d   = first_i ? '0 : idx_q;
    last_d    = (state_q == FILL) & stb_i & ~first_i & (idx_q == aw'(N - 1));
    publish_d = last_d & ~freeze_i;
    err_set_d = stb_i & ((state_q == IDLE) ? ~first_i : first_i);
  end

  // Capture always fills the back bank; the host only ever reads the front one.
  always_ff @(posedge clk_i) begin
    if (we_d) mem_q[{~bank_q, waddr_d}] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bank_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      h_data_q <= '0;
    end else begin
      h_data_q <= mem_q[{bank_q, h_addr_i}];
      done_q   <= publish_d;
      if (publish_d) bank_q <= ~bank_q;
      if (err_clr_i)      err_q <= 1'b0;
      else if (err_set_d) err_q <= 1'b1;
      case (state_q)
        IDLE: if (stb_i && first_i) begin
          idx_q   <= aw'(1);
          state_q <= FILL;
        end
        FILL: if (stb_i) begin
          if (first_i) idx_q <= aw'(1);
          else if (last_d) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end else idx_q <= idx_q + aw'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SLEW_CAPTURE_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)          cnt_q <= '0;
    else if (publish_d) cnt_q <= cnt_q + 16'd1;
  end
  assign frame_cnt_o = cnt_q;
`else
  assign frame_cnt_o = '0;
`endif

  assign h_data_o = h_data_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_slew_capture.sv
// Self-checking bench for slew_capture: directed scenarios plus randomized traffic,
// checked against a frame-level model (collected words, visible frame, sticky error).
module tb_slew_capture;
  localparam int DW = 18;
  localparam int AW = 3;
  localparam int N  = 8;

  logic                 clk = 1'b0;
  logic                 rst, stb, first, freeze, err_clr;
  logic signed [DW-1:0] din;
  logic        [AW-1:0] h_addr;
  logic signed [DW-1:0] h_data;
  logic                 done, err;
  logic        [15:0]   frame_cnt;

  always #5 clk = ~clk;

  slew_capture #(.dw(DW), .aw(AW)) dut (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .first_i(first), .din_i(din),
    .freeze_i(freeze), .err_clr_i(err_clr), .h_addr_i(h_addr),
    .h_data_o(h_data), .done_o(done), .err_o(err), .frame_cnt_o(frame_cnt)
  );

  // Frame-level model: words of the frame in progress, the frame the host sees.
  logic signed [DW-1:0] vis [N];
  bit                   vis_ok;
  logic signed [DW-1:0] acc [$];
  bit                   collecting;
  bit                   m_done, m_err;
  logic        [15:0]   m_cnt;
  logic signed [DW-1:0] exp_rd;
  bit                   exp_rd_ok;

  int nvec = 0;
  int nbad = 0;

  function automatic logic [15:0] exp_cnt();
`ifdef SLEW_CAPTURE_CNT_EN
    return m_cnt;
`else
    return 16'd0;
`endif
  endfunction

  // Drive one cycle and advance the model; outputs are valid on return (#1 after edge).
  task automatic step(input bit s, input bit f, input logic signed [DW-1:0] d);
    bit set_err;
    stb = s; first = f; din = d;
    exp_rd_ok = vis_ok;
    exp_rd    = vis[h_addr];
    @(posedge clk);
    m_done  = 1'b0;
    set_err = 1'b0;
    if (rst) begin
      collecting = 0; acc.delete(); vis_ok = 0; m_err = 0; m_cnt = '0;
      exp_rd_ok = 1'b1; exp_rd = '0;
    end else begin
      if (s) begin
        if (f) begin
          if (collecting) set_err = 1'b1;
          acc.delete(); acc.push_back(d); collecting = 1;
        end else if (!collecting) set_err = 1'b1;
        else begin
          acc.push_back(d);
          if (acc.size() == N) begin
            if (!freeze) begin
              for (int k = 0; k < N; k++) vis[k] = acc[k];
              vis_ok = 1; m_done = 1'b1; m_cnt = m_cnt + 16'd1;
            end
            acc.delete(); collecting = 0;
          end
        end
      end
      if (err_clr) m_err = 1'b0;
      else if (set_err) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; step(0, 0, '0); step(0, 0, '0);
    nvec++; if (done !== 1'b0)    begin nbad++; $display("FAIL reset_done: got %0b exp 0", done); end
    nvec++; if (err !== 1'b0)     begin nbad++; $display("FAIL reset_err: got %0b exp 0", err); end
    nvec++; if (h_data !== '0)    begin nbad++; $display("FAIL reset_hdata: got %0h exp 0", h_data); end
    nvec++; if (frame_cnt !== '0) begin nbad++; $display("FAIL reset_cnt: got %0h exp 0", frame_cnt); end
    rst = 0; step(0, 0, '0);
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] w;
    for (int v = 0; v < 2; v++) begin
      h_addr = 3'd2;
      for (int k = 0; k < N; k++) begin
        w = (v == 1 && k == 2) ? -18'sd5 : DW'(10 + k);
        step(1, k == 0, w);
        nvec++; if (done !== m_done) begin nbad++; $display("FAIL basic_done w%0d: got %0b exp %0b", k, done, m_done); end
        if (k == N - 1 && exp_rd_ok) begin
          nvec++; if (h_data !== exp_rd) begin nbad++; $display("FAIL basic_old_bank: got %0h exp %0h", h_data, exp_rd); end
        end
      end
      for (int k = 0; k < N; k++) begin
        h_addr = AW'(k); step(0, 0, '0);
        nvec++; if (h_data !== vis[k]) begin nbad++; $display("FAIL basic_rd ch%0d: got %0h exp %0h", k, h_data, vis[k]); end
        nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL basic_done_low: got %0b exp 0", done); end
      end
    end
    nvec++; if (err !== m_err) begin nbad++; $display("FAIL basic_err: got %0b exp %0b", err, m_err); end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < N; k++) begin
      if (k == 4) for (int g = 0; g < 3; g++) begin
        step(0, 0, DW'($urandom));
        nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL gap_done: got %0b exp 0", done); end
      end
      step(1, k == 0, DW'($urandom));
      nvec++; if (done !== m_done) begin nbad++; $display("FAIL gap_done w%0d: got %0b exp %0b", k, done, m_done); end
    end
    nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL gap_err: got %0b exp 0", err); end
    for (int k = 0; k < N; k++) begin
      h_addr = AW'(k); step(0, 0, '0);
      nvec++; if (h_data !== vis[k]) begin nbad++; $display("FAIL gap_rd ch%0d: got %0h exp %0h", k, h_data, vis[k]); end
    end
  endtask

  task automatic test_restart();
    int ndone = 0;
    for (int k = 0; k < 5; k++) begin step(1, k == 0, DW'(50 + k)); ndone += done; end
    for (int k = 0; k < N; k++) begin step(1, k == 0, DW'(100 + k)); ndone += done; end
    step(0, 0, '0); ndone += done;
    nvec++; if (ndone != 1) begin nbad++; $display("FAIL restart_ndone: got %0d exp 1", ndone); end
    nvec++; if (err !== 1'b1 || m_err !== 1'b1) begin nbad++; $display("FAIL restart_err: got %0b exp 1", err); end
    for (int k = 0; k < N; k++) begin
      h_addr = AW'(k); step(0, 0, '0);
      nvec++; if (h_data !== DW'(100 + k)) begin nbad++; $display("FAIL restart_rd ch%0d: got %0h exp %0h", k, h_data, 100 + k); end
    end
    err_clr = 1; step(0, 0, '0); err_clr = 0;
    nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL errclr: got %0b exp 0", err); end
    // clear and a same-cycle stray word: the clear must win
    err_clr = 1; step(1, 0, '0); err_clr = 0;
    nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL errclr_wins: got %0b exp 0", err); end
  endtask

  task automatic test_freeze();
    int ndone = 0;
    freeze = 1;
    for (int k = 0; k < N; k++) begin step(1, k == 0, DW'(200 + k)); ndone += done; end
    step(0, 0, '0); ndone += done;
    nvec++; if (ndone != 0) begin nbad++; $display("FAIL freeze_done: got %0d exp 0", ndone); end
    for (int k = 0; k < N; k++) begin
      h_addr = AW'(k); step(0, 0, '0);
      nvec++; if (h_data !== DW'(100 + k)) begin nbad++; $display("FAIL freeze_rd ch%0d: got %0h exp %0h", k, h_data, 100 + k); end
    end
    freeze = 0;
    for (int k = 0; k < N; k++) step(1, k == 0, DW'(300 + k));
    nvec++; if (done !== 1'b1) begin nbad++; $display("FAIL unfreeze_done: got %0b exp 1", done); end
    for (int k = 0; k < N; k++) begin
      h_addr = AW'(k); step(0, 0, '0);
      nvec++; if (h_data !== DW'(300 + k)) begin nbad++; $display("FAIL unfreeze_rd ch%0d: got %0h exp %0h", k, h_data, 300 + k); end
    end
    nvec++; if (frame_cnt !== exp_cnt()) begin nbad++; $display("FAIL freeze_cnt: got %0d exp %0d", frame_cnt, exp_cnt()); end
  endtask

  task automatic test_idle_err_rst();
    step(1, 0, 18'sd77);
    nvec++; if (err !== 1'b1) begin nbad++; $display("FAIL idle_err: got %0b exp 1", err); end
    for (int k = 0; k < N; k++) begin
      h_addr = AW'(k); step(0, 0, '0);
      nvec++; if (h_data !== vis[k]) begin nbad++; $display("FAIL idle_rd ch%0d: got %0h exp %0h", k, h_data, vis[k]); end
    end
    for (int k = 0; k < 4; k++) step(1, k == 0, DW'(400 + k));
    rst = 1; step(1, 0, DW'(404));
    nvec++; if (h_data !== '0)    begin nbad++; $display("FAIL rst_hdata: got %0h exp 0", h_data); end
    nvec++; if (done !== 1'b0)    begin nbad++; $display("FAIL rst_done: got %0b exp 0", done); end
    nvec++; if (frame_cnt !== '0) begin nbad++; $display("FAIL rst_cnt: got %0d exp 0", frame_cnt); end
    nvec++; if (err !== 1'b0)     begin nbad++; $display("FAIL rst_err: got %0b exp 0", err); end
    rst = 0;
    for (int k = 5; k < N; k++) begin
      step(1, 0, DW'(400 + k));
      nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL rst_nopub w%0d: got %0b exp 0", k, done); end
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    logic [15:0] c0;
    c0 = exp_cnt();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) begin step(1, k == 0, DW'($urandom)); ndone += done; end
    step(0, 0, '0); ndone += done;
    nvec++; if (ndone != 3) begin nbad++; $display("FAIL b2b_ndone: got %0d exp 3", ndone); end
    nvec++; if (frame_cnt !== exp_cnt()) begin nbad++; $display("FAIL b2b_cnt: got %0d exp %0d", frame_cnt, exp_cnt()); end
`ifdef SLEW_CAPTURE_CNT_EN
    nvec++; if (frame_cnt !== c0 + 16'd3) begin nbad++; $display("FAIL b2b_cnt3: got %0d exp %0d", frame_cnt, c0 + 16'd3); end
`endif
    for (int k = 0; k < N; k++) begin
      h_addr = AW'(k); step(0, 0, '0);
      nvec++; if (h_data !== vis[k]) begin nbad++; $display("FAIL b2b_rd ch%0d: got %0h exp %0h", k, h_data, vis[k]); end
    end
  endtask

  task automatic test_random();
    bit s, f;
    for (int i = 0; i < 1500; i++) begin
      s       = ($urandom % 4) != 0;
      f       = (acc.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 20) == 0);
      freeze  = ($urandom % 6) == 0;
      err_clr = ($urandom % 25) == 0;
      h_addr  = AW'($urandom);
      step(s, f, DW'($urandom));
      nvec++; if (done !== m_done) begin nbad++; $display("FAIL rnd_done @%0d: got %0b exp %0b", i, done, m_done); end
      nvec++; if (err !== m_err) begin nbad++; $display("FAIL rnd_err @%0d: got %0b exp %0b", i, err, m_err); end
      nvec++; if (frame_cnt !== exp_cnt()) begin nbad++; $display("FAIL rnd_cnt @%0d: got %0d exp %0d", i, frame_cnt, exp_cnt()); end
      if (exp_rd_ok) begin
        nvec++; if (h_data !== exp_rd) begin nbad++; $display("FAIL rnd_rd @%0d: got %0h exp %0h", i, h_data, exp_rd); end
      end
    end
    freeze = 0; err_clr = 0;
  endtask

  initial begin
    rst = 1; stb = 0; first = 0; din = '0; freeze = 0; err_clr = 0; h_addr = '0;
    vis_ok = 0; collecting = 0; m_done = 0; m_err = 0; m_cnt = '0;
    for (int k = 0; k < N; k++) vis[k] = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_freeze();
    test_idle_err_rst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
